// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port 32-bit
// word memory whose read data is registered (mem_RD valid one cycle after
// mem_A).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rN_req/we/be/addr/wdata    requester N (N=0,1) request inputs
//   rN_gnt, rN_err             accept pulse, with reject flag
//   rN_rvalid, rN_rdata        read-return pulse and data
//   mem_A, mem_WD, mem_MemWrite, mem_RD   memory side
//   dbg_state                  current FSM state (IDLE=0, RD_WAIT=1, RMW_MERGE=2)
//
// Handshake: a requester raises rN_req with stable we/be/addr/wdata and holds
// them until rN_gnt. The arbiter samples the inputs in the cycle rN_gnt is
// high; from the next cycle on the requester is free to change them. Reads
// return exactly one cycle after the grant as a one-cycle rN_rvalid pulse.
module mem_arbiter #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [3:0]  r0_be,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_err,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [3:0]  r1_be,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_err,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_RD,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RD_WAIT   = 2'd1;
  localparam logic [1:0] S_RMW_MERGE = 2'd2;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;     // port granted most recently
  logic        port_q, port_d;     // port owning the access in flight
  logic [29:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;       // in-flight read was rejected: return zero

  // Selected request in IDLE
  logic        sel_valid, sel;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr, sel_wdata;
  logic        addr_err;

  // Unqualified outputs, gated by rst_n below
  logic [1:0]  gnt_v;
  logic        err_v, rvalid_v, mw_v;
  logic [31:0] rdata_v, mem_a_v, wd_v;

  always_comb begin
    sel_valid = r0_req | r1_req;
    // On a tie the port not granted last wins; otherwise the lone requester.
    sel       = (r0_req & r1_req) ? ~last_q : r1_req;
    sel_we    = sel ? r1_we    : r0_we;
    sel_be    = sel ? r1_be    : r0_be;
    sel_addr  = sel ? r1_addr  : r0_addr;
    sel_wdata = sel ? r1_wdata : r0_wdata;
    addr_err  = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= MEM_WORDS_W);
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    err_d    = err_q;
    gnt_v    = 2'b00;
    err_v    = 1'b0;
    rvalid_v = 1'b0;
    rdata_v  = 32'h0;
    mem_a_v  = 32'h0;
    wd_v     = 32'h0;
    mw_v     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          gnt_v[sel] = 1'b1;
          err_v      = addr_err;
          last_d     = sel;
          port_d     = sel;
          idx_d      = sel_addr[31:2];
          wdata_d    = sel_wdata;
          be_d       = sel_be;
          err_d      = addr_err;
          if (addr_err) begin
            // Rejected reads still owe a (zero) read return next cycle.
            if (!sel_we) state_d = S_RD_WAIT;
          end else begin
            mem_a_v = {2'b00, sel_addr[31:2]};
            if (!sel_we) begin
              state_d = S_RD_WAIT;
            end else if (sel_be == 4'hF) begin
              mw_v = 1'b1;
              wd_v = sel_wdata;
            end else if (sel_be != 4'h0) begin
              // Read the old word now, merge and write it next cycle.
              state_d = S_RMW_MERGE;
            end
          end
        end
      end
      S_RD_WAIT: begin
        rvalid_v = 1'b1;
        rdata_v  = err_q ? 32'h0 : mem_RD;
        mem_a_v  = err_q ? 32'h0 : {2'b00, idx_q};
        state_d  = S_IDLE;
      end
      S_RMW_MERGE: begin
        mem_a_v = {2'b00, idx_q};
        mw_v    = 1'b1;
        for (int i = 0; i < 4; i++) begin
          wd_v[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_RD[8*i +: 8];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      idx_q   <= 30'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  // Outputs are combinational from state and inputs, so they are forced low
  // directly by rst_n to take effect without waiting for a clock edge.
  assign r0_gnt       = rst_n & gnt_v[0];
  assign r1_gnt       = rst_n & gnt_v[1];
  assign r0_err       = rst_n & gnt_v[0] & err_v;
  assign r1_err       = rst_n & gnt_v[1] & err_v;
  assign r0_rvalid    = rst_n & rvalid_v & ~port_q;
  assign r1_rvalid    = rst_n & rvalid_v & port_q;
  assign r0_rdata     = r0_rvalid ? rdata_v : 32'h0;
  assign r1_rdata     = r1_rvalid ? rdata_v : 32'h0;
  assign mem_A        = rst_n ? mem_a_v : 32'h0;
  assign mem_WD       = rst_n ? wd_v : 32'h0;
  assign mem_MemWrite = rst_n & mw_v;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized two-port traffic against
// mem_arbiter, with a transaction-level reference model of the arbiter and
// its memory checked on every falling clock edge.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [1:0]  req = 2'b00, we = 2'b00;
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  gnt, err, rvalid;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_MemWrite;
  logic [1:0]  dbg_state;

  mem_arbiter #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(req[0]), .r0_we(we[0]), .r0_be(be[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(gnt[0]), .r0_err(err[0]), .r0_rvalid(rvalid[0]), .r0_rdata(rdata0),
    .r1_req(req[1]), .r1_we(we[1]), .r1_be(be[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(gnt[1]), .r1_err(err[1]), .r1_rvalid(rvalid[1]), .r1_rdata(rdata1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_MemWrite(mem_MemWrite), .mem_RD(mem_RD),
    .dbg_state(dbg_state)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5555AAAA;
  endfunction

  // ---------------- memory fixture (registered read) ----------------
  logic [31:0] fix_mem [1024];
  bit          fix_wr  [1024];
  always @(posedge clk) begin
    if (mem_MemWrite && mem_A < 32'd1024) begin
      fix_mem[mem_A[9:0]] <= mem_WD;
      fix_wr[mem_A[9:0]]  <= 1'b1;
    end
    if (mem_A < 32'd1024)
      mem_RD <= fix_wr[mem_A[9:0]] ? fix_mem[mem_A[9:0]] : init_val(int'(mem_A));
    else
      mem_RD <= 32'h0;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: one access may be "owed" for the next cycle (a read
  // return or a merge write); otherwise the model arbitrates the inputs.
  logic [31:0] ref_mem [1024];
  bit          ref_init = 1'b0;
  int          m_last = 1;
  bit          m_busy = 1'b0, m_merge, m_err;
  int          m_port;
  logic [31:0] m_idx, m_data, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] exp_q [$];   // read data owed to the next rvalid

  logic [1:0]  e_gnt, e_err, e_rv;
  logic        e_mw, chk_a;
  logic [31:0] e_a, e_wd, e_rd, a, idx, merged;
  bit          bad;
  int          w;

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    e_gnt = 2'b00; e_err = 2'b00; e_rv = 2'b00; e_rd = 32'h0;
    e_mw = 1'b0; e_a = 32'h0; e_wd = 32'h0; chk_a = 1'b0;
    if (!rst_n) begin
      m_last = 1; m_busy = 1'b0; chk_a = 1'b1;
      exp_q.delete();
    end else if (m_busy) begin
      m_busy = 1'b0;
      if (m_merge) begin
        merged = ref_mem[m_idx[9:0]];
        for (int i = 0; i < 4; i++)
          if (m_be[i]) merged[8*i +: 8] = m_wdata[8*i +: 8];
        ref_mem[m_idx[9:0]] = merged;
        e_mw = 1'b1; e_a = m_idx; e_wd = merged; chk_a = 1'b1;
      end else begin
        e_rv[m_port] = 1'b1;
        e_rd = exp_q.pop_front();
        if (!m_err) begin e_a = m_idx; chk_a = 1'b1; end
      end
    end else if (req != 2'b00) begin
      if (req == 2'b11) w = (m_last == 0) ? 1 : 0;
      else              w = req[1] ? 1 : 0;
      a   = addr[w];
      idx = a >> 2;
      bad = (a[1:0] != 2'b00) || (idx >= 32'd1024);
      e_gnt[w] = 1'b1;
      e_err[w] = bad;
      m_last   = w;
      if (!we[w]) begin
        m_busy = 1'b1; m_merge = 1'b0; m_port = w; m_err = bad; m_idx = idx;
        exp_q.push_back(bad ? 32'h0 : ref_mem[idx[9:0]]);
        if (!bad) begin e_a = idx; chk_a = 1'b1; end
      end else if (!bad) begin
        if (be[w] == 4'hF) begin
          ref_mem[idx[9:0]] = wdata[w];
          e_mw = 1'b1; e_a = idx; e_wd = wdata[w]; chk_a = 1'b1;
        end else if (be[w] != 4'h0) begin
          m_busy = 1'b1; m_merge = 1'b1; m_idx = idx; m_wdata = wdata[w]; m_be = be[w];
        end
      end
    end
    check("gnt", {30'h0, gnt}, {30'h0, e_gnt});
    check("err", {30'h0, err}, {30'h0, e_err});
    check("rvalid", {30'h0, rvalid}, {30'h0, e_rv});
    check("mem_MemWrite", {31'h0, mem_MemWrite}, {31'h0, e_mw});
    if (chk_a) check("mem_A", mem_A, e_a);
    if (e_mw || !rst_n) check("mem_WD", mem_WD, e_wd);
    if (!rst_n) begin
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_rdata1", rdata1, 32'h0);
    end
    if (e_rv[0]) check("rdata0", rdata0, e_rd);
    if (e_rv[1]) check("rdata1", rdata1, e_rd);
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input int p, input logic w_i, input logic [3:0] b, input logic [31:0] ad,
                        input logic [31:0] d, output logic g_err, output logic g_mw,
                        output logic [31:0] g_a);
    bit got = 1'b0;
    g_err = 1'b0; g_mw = 1'b0; g_a = 32'h0;
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w_i; be[p] = b; addr[p] = ad; wdata[p] = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (gnt[p]) begin
        got = 1'b1; g_err = err[p]; g_mw = mem_MemWrite; g_a = mem_A;
      end
    end
    check("gnt_timeout", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic new_req(input int p);
    int k;
    req[p]   = 1'b1;
    we[p]    = 1'($urandom_range(0, 1));
    k        = $urandom_range(0, 7);
    be[p]    = (k < 3) ? 4'hF : (k == 3) ? 4'h0 : 4'($urandom_range(1, 14));
    k        = $urandom_range(0, 9);
    addr[p]  = 32'($urandom_range(0, 31)) << 2;
    if (k == 0) addr[p] = addr[p] + 32'($urandom_range(1, 3));
    if (k == 1) addr[p] = 32'h1000 + addr[p];
    if (k == 2) addr[p] = 32'hFFFF_FF00 + addr[p];
    wdata[p] = $urandom;
  endtask

  // ---------------- stimulus ----------------
  logic        g_err, g_mw;
  logic [31:0] g_a;
  logic [1:0]  gs;
  int          ng;
  bit          prev_g;

  initial begin
    for (int p = 0; p < 2; p++) begin be[p] = 4'h0; addr[p] = 32'h0; wdata[p] = 32'h0; end

    // Reset holds outputs low even with a full write waiting.
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'h1;
    #2;
    check("rst_gnt0", {31'h0, gnt[0]}, 32'h0);
    check("rst_mw", {31'h0, mem_MemWrite}, 32'h0);
    check("rst_mem_A", mem_A, 32'h0);
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both ports read every cycle: strict alternation, r0 first.
    req = 2'b11; we = 2'b00; addr[0] = 32'h8; addr[1] = 32'hC;
    ng = 0; prev_g = 1'b0;
    for (int c = 0; c < 40 && ng < 8; c++) begin
      @(negedge clk);
      if (prev_g) check("rdwait_no_gnt", {30'h0, gnt}, 32'h0);
      prev_g = 1'b0;
      if (gnt != 2'b00) begin
        check("tie_order", {30'h0, gnt}, (ng % 2 == 0) ? 32'h1 : 32'h2);
        ng++;
        prev_g = 1'b1;
      end
    end
    check("tie_count", ng, 8);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (2) @(posedge clk);

    // Full write then read back.
    do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, g_err, g_mw, g_a);
    check("fw_mw", {31'h0, g_mw}, 32'h1);
    check("fw_mem_A", g_a, 32'h4);
    check("fw_err", {31'h0, g_err}, 32'h0);
    do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, g_err, g_mw, g_a);
    @(negedge clk);
    check("rd_rvalid", {31'h0, rvalid[0]}, 32'h1);
    check("rd_rdata", rdata0, 32'hDEADBEEF);

    // Partial write: read-modify-write.
    do_req(0, 1'b1, 4'hF, 32'h20, 32'h11223344, g_err, g_mw, g_a);
    do_req(1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, g_err, g_mw, g_a);
    check("pw_T_mw", {31'h0, g_mw}, 32'h0);
    check("pw_T1_mw", {31'h0, mem_MemWrite}, 32'h1);
    check("pw_T1_wd", mem_WD, 32'h11BB33DD);
    check("pw_T1_a", mem_A, 32'h8);
    do_req(1, 1'b0, 4'h0, 32'h20, 32'h0, g_err, g_mw, g_a);
    @(negedge clk);
    check("pw_rdata", rdata1, 32'h11BB33DD);

    // Misaligned and out-of-range reads.
    do_req(0, 1'b0, 4'h0, 32'h1002, 32'h0, g_err, g_mw, g_a);
    check("mis_err", {31'h0, g_err}, 32'h1);
    check("mis_mw", {31'h0, g_mw}, 32'h0);
    @(negedge clk);
    check("mis_rvalid", {31'h0, rvalid[0]}, 32'h1);
    check("mis_rdata", rdata0, 32'h0);
    check("mis_mw1", {31'h0, mem_MemWrite}, 32'h0);
    do_req(0, 1'b0, 4'h0, 32'h1000, 32'h0, g_err, g_mw, g_a);
    check("oor_err", {31'h0, g_err}, 32'h1);
    @(negedge clk);
    check("oor_rdata", rdata0, 32'h0);
    check("oor_mw1", {31'h0, mem_MemWrite}, 32'h0);

    // be = 0 write leaves the word alone.
    do_req(0, 1'b1, 4'hF, 32'h40, 32'h5A5A5A5A, g_err, g_mw, g_a);
    do_req(0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, g_err, g_mw, g_a);
    check("be0_mw", {31'h0, g_mw}, 32'h0);
    check("be0_err", {31'h0, g_err}, 32'h0);
    do_req(0, 1'b0, 4'h0, 32'h40, 32'h0, g_err, g_mw, g_a);
    @(negedge clk);
    check("be0_rdata", rdata0, 32'h5A5A5A5A);

    // Reset during RMW_MERGE aborts the merge write.
    do_req(0, 1'b1, 4'hF, 32'h80, 32'h01020304, g_err, g_mw, g_a);
    do_req(1, 1'b1, 4'b1000, 32'h80, 32'hFF000000, g_err, g_mw, g_a);
    check("rmw_mw_before", {31'h0, mem_MemWrite}, 32'h1);
    #1; rst_n = 1'b0;
    #1;
    check("rmw_abort_mw", {31'h0, mem_MemWrite}, 32'h0);
    repeat (2) @(posedge clk);
    check("rmw_word", fix_mem[32], 32'h01020304);
    #1; rst_n = 1'b1;
    req = 2'b11; we = 2'b00; addr[0] = 32'h80; addr[1] = 32'h84;
    ng = 0;
    for (int c = 0; c < 20 && ng < 2; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        check("post_rst_tie", {30'h0, gnt}, (ng == 0) ? 32'h1 : 32'h2);
        ng++;
        @(posedge clk); #1;
        req = req & ~gnt;
      end
    end
    check("post_rst_count", ng, 2);
    req = 2'b00;
    repeat (3) @(posedge clk);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gs = gnt;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (req[p] && gs[p]) req[p] = 1'b0;
        if (!req[p] && $urandom_range(0, 2) != 0) new_req(p);
      end
    end
    req = 2'b00;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
